hist_uart_dumper: RTL and testbench

- Consumer end of the histogram readout interface driven by the p-bit histogram logger: `freeze`, `hist_sel`, `hist_data`.
- Once the logger freezes, it advances `hist_sel` one entry per clock with no handshake. This block captures that full-rate sweep into a local buffer.
- It then serializes the buffer off-chip as one UART frame (8N1) for host-side plotting. This replaces ILA-based readout on boards without JTAG access.

---
 rtl/hist_uart_dumper.sv | 219 +++++++++++++++++++++
 tb/tb_hist_uart_dumper.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_uart_dumper.sv
// Captures one full-rate histogram sweep from the logger into a local buffer and
// ships it off-chip as a single 8N1 UART frame: header, count, data bytes, checksum.
module hist_uart_dumper #(
    parameter int         NUM_ENTRIES  = 90,
    parameter int         SEL_W        = 7,
    parameter int         DATA_W       = 32,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HDR_BYTE     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze,
    input  logic [SEL_W-1:0]  hist_sel,
    input  logic [DATA_W-1:0] hist_data,
    input  logic              resend,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int DATA_BYTES = (DATA_W + 7) / 8;
    localparam int PAD_W      = DATA_BYTES * 8;
    localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int BYTE_W     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE, CAPTURE, TX_HDR, TX_CNT, TX_DATA, TX_CSUM, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clkCnt_q, clkCnt_d;
    logic [3:0]         bitIdx_q, bitIdx_d;
    logic [8:0]         shReg_q, shReg_d;
    logic               tx_q, tx_d;
    logic               active_q, active_d;
    logic [7:0]         csum_q, csum_d;
    logic [IDX_W-1:0]   entIdx_q, entIdx_d;
    logic [BYTE_W-1:0]  byteIdx_q, byteIdx_d;
    logic               lastLoaded_q, lastLoaded_d;

    logic [DATA_W-1:0]  mem [NUM_ENTRIES];
    logic [DATA_W-1:0]  rdData_q;
    logic [PAD_W-1:0]   padded;
    logic [7:0]         dataByte;
    logic [7:0]         loadByte;
    logic               memWe, loadEn, dataLoad;
    logic               selInRange, selIsLast, bitEnd, byteEnd, dataIsLast;

    assign selInRange = ({1'b0, hist_sel} <  (SEL_W+1)'(NUM_ENTRIES));
    assign selIsLast  = ({1'b0, hist_sel} == (SEL_W+1)'(NUM_ENTRIES - 1));
    assign bitEnd     = active_q && (clkCnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign byteEnd    = bitEnd && (bitIdx_q == 4'd9);
    assign dataIsLast = (entIdx_q == IDX_W'(NUM_ENTRIES - 1)) &&
                        (byteIdx_q == BYTE_W'(DATA_BYTES - 1));
    assign padded     = PAD_W'(rdData_q);
    assign dataByte   = 8'(padded >> (8 * byteIdx_q));

    // Registered read runs every cycle; the entry index only moves at byte loads,
    // so the word is settled long before the next load needs it.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[hist_sel[IDX_W-1:0]] <= hist_data;
        end
        rdData_q <= mem[entIdx_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            clkCnt_q     <= '0;
            bitIdx_q     <= '0;
            shReg_q      <= '1;
            tx_q         <= 1'b1;
            active_q     <= 1'b0;
            csum_q       <= '0;
            entIdx_q     <= '0;
            byteIdx_q    <= '0;
            lastLoaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clkCnt_q     <= clkCnt_d;
            bitIdx_q     <= bitIdx_d;
            shReg_q      <= shReg_d;
            tx_q         <= tx_d;
            active_q     <= active_d;
            csum_q       <= csum_d;
            entIdx_q     <= entIdx_d;
            byteIdx_q    <= byteIdx_d;
            lastLoaded_q <= lastLoaded_d;
        end
    end

    // The state names the byte currently on the wire; the next byte is loaded on
    // the edge that ends the previous stop bit, so bytes run back-to-back.
    always_comb begin
        state_d      = state_q;
        clkCnt_d     = clkCnt_q;
        bitIdx_d     = bitIdx_q;
        shReg_d      = shReg_q;
        tx_d         = tx_q;
        active_d     = active_q;
        csum_d       = csum_q;
        entIdx_d     = entIdx_q;
        byteIdx_d    = byteIdx_q;
        lastLoaded_d = lastLoaded_q;
        memWe        = 1'b0;
        loadEn       = 1'b0;
        dataLoad     = 1'b0;
        loadByte     = '0;

        if (active_q) begin
            if (bitEnd) begin
                clkCnt_d = '0;
                bitIdx_d = bitIdx_q + 4'd1;
                tx_d     = shReg_q[0];
                shReg_d  = {1'b1, shReg_q[8:1]};
            end else begin
                clkCnt_d = clkCnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (freeze) begin
                    memWe   = selInRange;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!freeze) begin
                    state_d = IDLE;
                end else begin
                    memWe = selInRange;
                    if (selIsLast) begin
                        state_d      = TX_HDR;
                        csum_d       = '0;
                        entIdx_d     = '0;
                        byteIdx_d    = '0;
                        lastLoaded_d = 1'b0;
                    end
                end
            end
            TX_HDR: begin
                if (!active_q) begin
                    loadEn   = 1'b1;
                    loadByte = HDR_BYTE;
                end else if (byteEnd) begin
                    loadEn   = 1'b1;
                    loadByte = 8'(NUM_ENTRIES);
                    csum_d   = csum_q ^ 8'(NUM_ENTRIES);
                    state_d  = TX_CNT;
                end
            end
            TX_CNT: begin
                if (byteEnd) begin
                    dataLoad = 1'b1;
                    state_d  = TX_DATA;
                end
            end
            TX_DATA: begin
                if (byteEnd) begin
                    if (lastLoaded_q) begin
                        loadEn   = 1'b1;
                        loadByte = csum_q;
                        state_d  = TX_CSUM;
                    end else begin
                        dataLoad = 1'b1;
                    end
                end
            end
            TX_CSUM: begin
                if (byteEnd) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (resend) begin
                    state_d      = TX_HDR;
                    csum_d       = '0;
                    entIdx_d     = '0;
                    byteIdx_d    = '0;
                    lastLoaded_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dataLoad) begin
            loadEn       = 1'b1;
            loadByte     = dataByte;
            csum_d       = csum_q ^ dataByte;
            lastLoaded_d = dataIsLast;
            if (!dataIsLast) begin
                if (byteIdx_q == BYTE_W'(DATA_BYTES - 1)) begin
                    byteIdx_d = '0;
                    entIdx_d  = entIdx_q + 1'b1;
                end else begin
                    byteIdx_d = byteIdx_q + 1'b1;
                end
            end
        end

        if (loadEn) begin
            tx_d     = 1'b0;
            shReg_d  = {1'b1, loadByte};
            bitIdx_d = '0;
            clkCnt_d = '0;
            active_d = 1'b1;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_hist_uart_dumper.sv
// Directed bench for hist_uart_dumper: sweeps from a vector table, decodes the UART
// line bit-by-bit at the configured bit period and compares against hand-built frames.
module tb_hist_uart_dumper;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  histSel;
    logic        freezeA, resendA, txA, busyA, doneA;
    logic [15:0] histDataA;
    logic        freezeB, resendB, txB, busyB, doneB;
    logic [11:0] histDataB;

    always #5 clk = ~clk;

    hist_uart_dumper #(
        .NUM_ENTRIES(4), .SEL_W(3), .DATA_W(16), .CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5)
    ) dutA (
        .clk(clk), .reset_n(reset_n), .freeze(freezeA), .hist_sel(histSel),
        .hist_data(histDataA), .resend(resendA), .tx(txA), .busy(busyA), .done(doneA)
    );

    hist_uart_dumper #(
        .NUM_ENTRIES(2), .SEL_W(3), .DATA_W(12), .CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5)
    ) dutB (
        .clk(clk), .reset_n(reset_n), .freeze(freezeB), .hist_sel(histSel),
        .hist_data(histDataB), .resend(resendB), .tx(txB), .busy(busyB), .done(doneB)
    );

    typedef struct {
        logic        frz;
        logic [2:0]  sel;
        logic [15:0] data;
        logic        expBusy;
    } sweepVec_t;

    sweepVec_t  sweepTab[16];
    logic [7:0] expBytes[16];
    logic [7:0] rxBytes[16];
    int         checks = 0;
    int         errors = 0;
    bit         bArmed = 1'b0;
    int         txBLowEarly = 0;

    // Unit B stays unfrozen until the last test, so its line must never leave idle.
    always @(negedge clk) begin
        if (!bArmed && txB !== 1'b1) txBLowEarly++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkSweep(input int i, input bit useB);
        checkOutput($sformatf("sweep vec %0d busy", i),
                    32'(useB ? busyB : busyA), 32'(sweepTab[i].expBusy));
        checkOutput($sformatf("sweep vec %0d tx idle", i),
                    32'(useB ? txB : txA), 32'd1);
    endtask

    task automatic applyStimulus(input int first, input int last, input bit useB);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            if (i > first) checkSweep(i - 1, useB);
            histSel = sweepTab[i].sel;
            if (useB) begin
                freezeB   = sweepTab[i].frz;
                histDataB = sweepTab[i].data[11:0];
            end else begin
                freezeA   = sweepTab[i].frz;
                histDataA = sweepTab[i].data;
            end
        end
        @(negedge clk);
        checkSweep(last, useB);
    endtask

    task automatic setFrame(input int which);
        logic [7:0] f1[11] = '{8'hA5, 8'h04, 8'h02, 8'h01, 8'h04, 8'h03,
                               8'h06, 8'h05, 8'h08, 8'h07, 8'h0C};
        logic [7:0] f3[11] = '{8'hA5, 8'h04, 8'h02, 8'h01, 8'h04, 8'h03,
                               8'h07, 8'h00, 8'h08, 8'h07, 8'h08};
        logic [7:0] f6[7]  = '{8'hA5, 8'h02, 8'hBC, 8'h0A, 8'h23, 8'h01, 8'h96};
        for (int k = 0; k < 16; k++) expBytes[k] = 8'h00;
        case (which)
            1:       for (int k = 0; k < 11; k++) expBytes[k] = f1[k];
            3:       for (int k = 0; k < 11; k++) expBytes[k] = f3[k];
            default: for (int k = 0; k < 7; k++)  expBytes[k] = f6[k];
        endcase
    endtask

    // Every cycle of every bit is sampled, so a bit that is short, long or
    // split shows up as a glitch and shifts all later bytes.
    task automatic recvFrame(input bit useB, input int nBytes, input string tag);
        int         waitCycles;
        int         glitches;
        int         framing;
        logic       s;
        logic [9:0] bits;
        bit         first;
        waitCycles = 0;
        glitches   = 0;
        framing    = 0;
        bits       = '0;
        s          = 1'b1;
        while (s !== 1'b0 && waitCycles < 2000) begin
            @(negedge clk);
            waitCycles++;
            s = useB ? txB : txA;
        end
        if (s !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s start: no start bit within %0d cycles", tag, waitCycles);
            return;
        end
        checkOutput({tag, " start latency"}, 32'(waitCycles), 32'd1);
        first = 1'b1;
        for (int b = 0; b < nBytes; b++) begin
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (!first) begin
                        @(negedge clk);
                        s = useB ? txB : txA;
                    end
                    first = 1'b0;
                    if (c == 0) bits[k] = s;
                    else if (s !== bits[k]) glitches++;
                end
            end
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1) framing++;
            rxBytes[b] = bits[8:1];
        end
        for (int b = 0; b < nBytes; b++) begin
            checkOutput($sformatf("%s byte %0d", tag, b), 32'(rxBytes[b]), 32'(expBytes[b]));
        end
        checkOutput({tag, " bit timing"}, 32'(glitches), 32'd0);
        checkOutput({tag, " framing"}, 32'(framing), 32'd0);
        @(negedge clk);
        checkOutput({tag, " done after frame"}, 32'(useB ? doneB : doneA), 32'd1);
        checkOutput({tag, " busy after frame"}, 32'(useB ? busyB : busyA), 32'd0);
        checkOutput({tag, " tx after frame"}, 32'(useB ? txB : txA), 32'd1);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int lowCnt;
        int busyCnt;
        int waitCnt;

        sweepTab[0]  = '{1'b1, 3'd0, 16'h0102, 1'b1};
        sweepTab[1]  = '{1'b1, 3'd1, 16'h0304, 1'b1};
        sweepTab[2]  = '{1'b1, 3'd2, 16'h0506, 1'b1};
        sweepTab[3]  = '{1'b1, 3'd3, 16'h0708, 1'b1};
        sweepTab[4]  = '{1'b1, 3'd0, 16'h1111, 1'b1};
        sweepTab[5]  = '{1'b1, 3'd1, 16'h2222, 1'b1};
        sweepTab[6]  = '{1'b0, 3'd2, 16'h3333, 1'b0};
        sweepTab[7]  = '{1'b1, 3'd0, 16'h0102, 1'b1};
        sweepTab[8]  = '{1'b1, 3'd1, 16'h0304, 1'b1};
        sweepTab[9]  = '{1'b1, 3'd2, 16'h0005, 1'b1};
        sweepTab[10] = '{1'b1, 3'd2, 16'h0006, 1'b1};
        sweepTab[11] = '{1'b1, 3'd2, 16'h0007, 1'b1};
        sweepTab[12] = '{1'b1, 3'd5, 16'hDEAD, 1'b1};
        sweepTab[13] = '{1'b1, 3'd3, 16'h0708, 1'b1};
        sweepTab[14] = '{1'b1, 3'd0, 16'h0ABC, 1'b1};
        sweepTab[15] = '{1'b1, 3'd1, 16'h0123, 1'b1};

        freezeA = 1'b0; resendA = 1'b0; histDataA = '0;
        freezeB = 1'b0; resendB = 1'b0; histDataB = '0;
        histSel = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("reset tx A", 32'(txA), 32'd1);
        checkOutput("reset busy A", 32'(busyA), 32'd0);
        checkOutput("reset done A", 32'(doneA), 32'd0);
        checkOutput("reset tx B", 32'(txB), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] test 1: basic sweep and frame");
        applyStimulus(0, 3, 1'b0);
        setFrame(1);
        recvFrame(1'b0, 11, "T1");

        $display("[TB] test 4: resend, with a second resend pulse mid-frame");
        @(negedge clk); resendA = 1'b1;
        @(negedge clk); resendA = 1'b0;
        fork
            begin
                repeat (100) @(negedge clk);
                resendA = 1'b1;
                @(negedge clk);
                resendA = 1'b0;
            end
        join_none
        recvFrame(1'b0, 11, "T4");
        repeat (10) @(negedge clk);
        checkOutput("T4 done holds", 32'(doneA), 32'd1);
        checkOutput("T4 line idle", 32'(txA), 32'd1);

        $display("[TB] test 5: reset mid-frame");
        @(negedge clk); resendA = 1'b1;
        @(negedge clk); resendA = 1'b0;
        repeat (150) @(negedge clk);
        waitCnt = 0;
        while (txA !== 1'b0 && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("T5 found low bit", 32'(txA), 32'd0);
        freezeA = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("T5 async tx", 32'(txA), 32'd1);
        checkOutput("T5 async busy", 32'(busyA), 32'd0);
        checkOutput("T5 async done", 32'(doneA), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        lowCnt = 0;
        busyCnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txA !== 1'b1) lowCnt++;
            if (busyA !== 1'b0) busyCnt++;
        end
        checkOutput("T5 no tx after reset", 32'(lowCnt), 32'd0);
        checkOutput("T5 not busy after reset", 32'(busyCnt), 32'd0);

        $display("[TB] test 2: freeze abort then full sweep");
        applyStimulus(4, 6, 1'b0);
        checkOutput("T2 done after abort", 32'(doneA), 32'd0);
        lowCnt = 0;
        busyCnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (txA !== 1'b1) lowCnt++;
            if (busyA !== 1'b0) busyCnt++;
        end
        checkOutput("T2 idle line after abort", 32'(lowCnt), 32'd0);
        checkOutput("T2 idle busy after abort", 32'(busyCnt), 32'd0);
        applyStimulus(0, 3, 1'b0);
        setFrame(1);
        recvFrame(1'b0, 11, "T2");

        $display("[TB] test 3: stalled and out-of-range select");
        freezeA = 1'b0;
        doReset();
        applyStimulus(7, 13, 1'b0);
        setFrame(3);
        recvFrame(1'b0, 11, "T3");

        $display("[TB] test 6: 12-bit data with pad bits");
        checkOutput("T6 line idle before frame", 32'(txBLowEarly), 32'd0);
        bArmed = 1'b1;
        applyStimulus(14, 15, 1'b1);
        setFrame(6);
        recvFrame(1'b1, 7, "T6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
